// File: rtl/fetch_redirect_sched_pkg.sv
// fetch_redirect_sched_pkg: shared fetch encodings for the redirect source and the redirect FSM state
package fetch_redirect_sched_pkg;
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'b00,
    REDIR_ID     = 2'b01,
    REDIR_EX     = 2'b10,
    REDIR_COMMIT = 2'b11
  } redir_src_e;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } fsm_state_e;
endpackage

// File: rtl/redirect_prio_sel.sv
// redirect_prio_sel: commit > EX > ID priority mux with state-based accept mask; ports: three req/pc pairs, state, in-flight src in; accept/src/pc out
module redirect_prio_sel
  import fetch_redirect_sched_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            commit_req,
  input  logic [PC_W-1:0] commit_pc,
  input  logic            ex_req,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            id_req,
  input  logic [PC_W-1:0] id_pc,
  input  fsm_state_e      state,
  input  redir_src_e      cur_src,
  output logic            accept,
  output redir_src_e      src,
  output logic [PC_W-1:0] pc
);
  logic idle;
  logic ex_ok;
  logic id_ok;
  assign idle = state == IDLE;
  // EX cannot override a commit redirect still in flight; ID only matters when nothing is in flight
  assign ex_ok = ex_req && (idle || cur_src != REDIR_COMMIT);
  assign id_ok = id_req && idle;
  always_comb begin
    accept = commit_req || ex_ok || id_ok;
    src = commit_req ? REDIR_COMMIT : ex_ok ? REDIR_EX : id_ok ? REDIR_ID : REDIR_NONE;
    pc = commit_req ? commit_pc : ex_ok ? ex_pc : id_pc;
  end
endmodule

// File: rtl/fetch_redirect_sched.sv
// fetch_redirect_sched: arbitrates commit/EX/ID redirects, pulses redirect PC, flushes fetch for FLUSH_CYCLES then waits for refill; optional REDIRECT_STATS_EN adds per-source counters and statClr_i
module fetch_redirect_sched
  import fetch_redirect_sched_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commitRedirect_i,
  input  logic [PC_W-1:0] commitPC_i,
  input  logic            exRedirect_i,
  input  logic [PC_W-1:0] exPC_i,
  input  logic            idRedirect_i,
  input  logic [PC_W-1:0] idPC_i,
  input  logic            fs1Ready_i,
`ifdef REDIRECT_STATS_EN
  input  logic            statClr_i,
  output logic [CNT_W-1:0] statCommit_o,
  output logic [CNT_W-1:0] statEx_o,
  output logic [CNT_W-1:0] statId_o,
`endif
  output logic            redirectValid_o,
  output logic [PC_W-1:0] redirectPC_o,
  output logic [1:0]      redirectSrc_o,
  output logic            flushFS1_o,
  output logic            flushFS2_o,
  output logic            stallFetch_o,
  output logic            busy_o
);
  fsm_state_e      state, state_n;
  logic [3:0]      cnt, cnt_n;
  redir_src_e      src_q, sel_src;
  logic [PC_W-1:0] sel_pc;
  logic            accept;
  redirect_prio_sel #(.PC_W(PC_W)) u_sel (
    .commit_req(commitRedirect_i),
    .commit_pc (commitPC_i),
    .ex_req    (exRedirect_i),
    .ex_pc     (exPC_i),
    .id_req    (idRedirect_i),
    .id_pc     (idPC_i),
    .state     (state),
    .cur_src   (src_q),
    .accept    (accept),
    .src       (sel_src),
    .pc        (sel_pc)
  );
  assign redirectSrc_o = src_q;
  // any accepted redirect (including preemption) restarts the flush window
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept) begin
      state_n = FLUSH;
      cnt_n = 4'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state_n = cnt == 4'd0 ? REFILL : FLUSH;
      cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state == REFILL && fs1Ready_i) begin
      state_n = IDLE;
    end
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      src_q <= REDIR_NONE;
      redirectValid_o <= 1'b0;
      redirectPC_o <= '0;
      flushFS1_o <= 1'b0;
      flushFS2_o <= 1'b0;
      stallFetch_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      redirectValid_o <= accept;
      if (accept) begin
        src_q <= sel_src;
        redirectPC_o <= sel_pc;
      end
      flushFS1_o <= state_n == FLUSH;
      flushFS2_o <= state_n == FLUSH;
      stallFetch_o <= state_n == FLUSH;
      busy_o <= state_n != IDLE;
    end
  end
`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statCommit_o <= '0;
      statEx_o <= '0;
      statId_o <= '0;
    end else if (statClr_i) begin
      statCommit_o <= '0;
      statEx_o <= '0;
      statId_o <= '0;
    end else if (accept) begin
      if (sel_src == REDIR_COMMIT && !(&statCommit_o)) statCommit_o <= statCommit_o + 1'b1;
      if (sel_src == REDIR_EX && !(&statEx_o)) statEx_o <= statEx_o + 1'b1;
      if (sel_src == REDIR_ID && !(&statId_o)) statId_o <= statId_o + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_fetch_redirect_sched.sv
// tb_fetch_redirect_sched: vector table, corner sequences and random run against a behavioural model of fetch_redirect_sched
module tb_fetch_redirect_sched;
  localparam int F = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic c_req = 1'b0, e_req = 1'b0, i_req = 1'b0, rdy = 1'b0;
  logic [31:0] c_pc = '0, e_pc = '0, i_pc = '0;
  logic redirectValid_o, flushFS1_o, flushFS2_o, stallFetch_o, busy_o;
  logic [31:0] redirectPC_o;
  logic [1:0] redirectSrc_o;
`ifdef REDIRECT_STATS_EN
  logic stat_clr = 1'b0;
  logic [1:0] statCommit_o, statEx_o, statId_o;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fetch_redirect_sched #(.PC_W(32), .FLUSH_CYCLES(F), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .commitRedirect_i(c_req),
    .commitPC_i(c_pc),
    .exRedirect_i(e_req),
    .exPC_i(e_pc),
    .idRedirect_i(i_req),
    .idPC_i(i_pc),
    .fs1Ready_i(rdy),
`ifdef REDIRECT_STATS_EN
    .statClr_i(stat_clr),
    .statCommit_o(statCommit_o),
    .statEx_o(statEx_o),
    .statId_o(statId_o),
`endif
    .redirectValid_o(redirectValid_o),
    .redirectPC_o(redirectPC_o),
    .redirectSrc_o(redirectSrc_o),
    .flushFS1_o(flushFS1_o),
    .flushFS2_o(flushFS2_o),
    .stallFetch_o(stallFetch_o),
    .busy_o(busy_o)
  );
  typedef struct packed {
    logic c, e, i, r;
    logic [31:0] cpc, epc, ipc;
    logic v;
    logic [31:0] xpc;
    logic [1:0] xs;
    logic f, b;
  } vec_t;
  vec_t tbl[$];
  // model: flush cycles still to show, waiting-for-refill flag, last issued redirect
  int m_fl;
  logic m_rf, m_v;
  logic [31:0] m_pc;
  logic [1:0] m_src;
  function automatic logic [38:0] outs();
    return {redirectValid_o, redirectPC_o, redirectSrc_o, flushFS1_o, flushFS2_o, stallFetch_o, busy_o};
  endfunction
  function automatic logic [38:0] mk(logic v, logic [31:0] pc, logic [1:0] s, logic f, logic b);
    return {v, pc, s, f, f, f, b};
  endfunction
  task automatic chk(input string nm, input logic [38:0] act, input logic [38:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%b pc=%h src=%b f1/f2/st=%b%b%b busy=%b, want v=%b pc=%h src=%b f1/f2/st=%b%b%b busy=%b",
               nm, act[38], act[37:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[38], exp[37:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic drive(input logic c, e, i, r, input logic [31:0] cp, ep, ip);
    c_req = c; e_req = e; i_req = i; rdy = r; c_pc = cp; e_pc = ep; i_pc = ip;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_fl = 0; m_rf = 1'b0; m_v = 1'b0; m_pc = '0; m_src = 2'b00;
  endtask
  task automatic model_step();
    logic busy, tc, te, ti;
    busy = m_fl > 0 || m_rf;
    tc = c_req;
    te = !tc && e_req && (!busy || m_src != 2'b11);
    ti = !tc && !te && i_req && !busy;
    if (tc || te || ti) begin
      m_v = 1'b1;
      m_pc = tc ? c_pc : te ? e_pc : i_pc;
      m_src = tc ? 2'b11 : te ? 2'b10 : 2'b01;
      m_fl = F;
      m_rf = 1'b0;
    end else begin
      m_v = 1'b0;
      if (m_fl > 0) begin
        m_fl--;
        if (m_fl == 0) m_rf = 1'b1;
      end else if (m_rf && rdy) m_rf = 1'b0;
    end
  endtask
  initial begin
    tbl.push_back('{0,0,1,0, 32'h0,32'h0,32'h400,     1,32'h400,2'b01,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h400,2'b01,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h400,2'b01,0,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h400,2'b01,0,0});
    tbl.push_back('{1,1,1,0, 32'h100,32'h200,32'h300, 1,32'h100,2'b11,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h100,2'b11,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h100,2'b11,0,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h100,2'b11,0,0});
    tbl.push_back('{0,1,0,0, 32'h0,32'h200,32'h0,     1,32'h200,2'b10,1,1});
    tbl.push_back('{0,0,1,0, 32'h0,32'h0,32'h300,     0,32'h200,2'b10,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h200,2'b10,0,1});
    tbl.push_back('{1,0,0,0, 32'h80,32'h0,32'h0,      1,32'h80,2'b11,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h80,2'b11,1,1});
    tbl.push_back('{0,1,0,0, 32'h0,32'h200,32'h0,     0,32'h80,2'b11,0,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h80,2'b11,0,0});
    tbl.push_back('{0,1,0,0, 32'h0,32'h500,32'h0,     1,32'h500,2'b10,1,1});
    tbl.push_back('{0,1,0,0, 32'h0,32'h600,32'h0,     1,32'h600,2'b10,1,1});
    tbl.push_back('{1,0,0,0, 32'h700,32'h0,32'h0,     1,32'h700,2'b11,1,1});
    tbl.push_back('{1,0,0,0, 32'h704,32'h0,32'h0,     1,32'h704,2'b11,1,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h704,2'b11,1,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h704,2'b11,0,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h704,2'b11,0,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'h704,2'b11,0,0});
    tbl.push_back('{0,1,0,0, 32'h0,32'h900,32'h0,     1,32'h900,2'b10,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h900,2'b10,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'h900,2'b10,0,1});
    tbl.push_back('{0,1,0,0, 32'h0,32'ha00,32'h0,     1,32'ha00,2'b10,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'ha00,2'b10,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,32'h0,32'h0,       0,32'ha00,2'b10,0,1});
    tbl.push_back('{0,0,0,1, 32'h0,32'h0,32'h0,       0,32'ha00,2'b10,0,0});
    repeat (3) tick();
    chk("reset", outs(), '0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle%0d", k), outs(), '0);
    end
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].c, tbl[k].e, tbl[k].i, tbl[k].r, tbl[k].cpc, tbl[k].epc, tbl[k].ipc);
      tick();
      chk($sformatf("vec%0d", k), outs(), mk(tbl[k].v, tbl[k].xpc, tbl[k].xs, tbl[k].f, tbl[k].b));
    end
    drive(0, 1, 0, 0, 0, 32'h1234, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_pulse", outs(), mk(1, 32'h1234, 2'b10, 1, 1));
    #2 reset = 1'b0;
    #1 chk("async_rst", outs(), '0);
    tick();
    chk("rst_held", outs(), '0);
    reset = 1'b1;
    tick();
    chk("post_rst_idle", outs(), '0);
    drive(0, 0, 1, 0, 0, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_id", outs(), mk(1, 32'h40, 2'b01, 1, 1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom, $urandom, $urandom);
      model_step();
      tick();
      chk($sformatf("rand%0d", k), outs(), mk(m_v, m_pc, m_src, m_fl > 0, m_fl > 0 || m_rf));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef REDIRECT_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, 32'h10 + k, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (statEx_o !== 2'd3 || statCommit_o !== 2'd0 || statId_o !== 2'd0) begin
      n_err++;
      $display("FAIL stat_sat: got ex=%0d c=%0d id=%0d, want 3 0 0", statEx_o, statCommit_o, statId_o);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_cmp++;
    if (statEx_o !== 2'd0) begin
      n_err++;
      $display("FAIL stat_clr: got ex=%0d, want 0", statEx_o);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
